// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the d_flip_flop register / delay-line family.
package d_flip_flop_pkg;

  // Supported range of cascaded stages.
  localparam int DFF_DEPTH_MIN = 1;
  localparam int DFF_DEPTH_MAX = 64;

  // Forces a requested depth into the supported range. An out-of-range
  // value then still elaborates to a sane chain instead of an empty or
  // enormous one.
  function automatic int dff_clamp_depth(input int depth);
    if (depth < DFF_DEPTH_MIN) begin
      return DFF_DEPTH_MIN;
    end
    if (depth > DFF_DEPTH_MAX) begin
      return DFF_DEPTH_MAX;
    end
    return depth;
  endfunction

endpackage

// File: rtl/d_flip_flop_if.sv
// Data/enable bundle for d_flip_flop. The master drives EN and D, and the
// slave (the register chain) returns Q and QN.
interface d_flip_flop_if #(
  parameter int WIDTH = 1
);
  logic             EN;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;

  modport master (output EN, output D, input Q, input QN);
  modport slave  (input EN, input D, output Q, output QN);
endinterface

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register stage with enable and asynchronous active-low clear.
module d_ff_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next state: capture D when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (EN) begin
      data_d = D;
    end
  end

  // Storage: clear is asynchronous and takes priority over any clock edge.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign Q = data_q;

endmodule

// File: rtl/d_flip_flop.sv
// D flip-flop generalised to a WIDTH-bit, DEPTH-stage register chain.
// DEPTH=1 is a plain flop/register, and larger DEPTH gives a fixed-latency
// delay line. Q comes straight from the last stage, and QN is its complement.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic          CLK,
  input  logic          CLR,
  d_flip_flop_if.slave  bus
);

  localparam int N_STAGES = dff_clamp_depth(DEPTH);

  logic [WIDTH-1:0] stage_q [N_STAGES];

  // Register chain: stage 0 takes D, and each later stage takes its
  // predecessor. All stages share EN, so the whole line advances or holds.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] stage_in;

    if (i == 0) begin : g_head
      assign stage_in = bus.D;
    end else begin : g_link
      assign stage_in = stage_q[i-1];
    end

    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .CLK (CLK),
      .CLR (CLR),
      .EN  (bus.EN),
      .D   (stage_in),
      .Q   (stage_q[i])
    );
  end

  assign bus.Q  = stage_q[N_STAGES-1];
  assign bus.QN = ~stage_q[N_STAGES-1];

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit single flop (A) and an 8-bit
// 3-stage delay line with reset value 8'hA5 (B), sharing one clock.
module tb_d_flip_flop;

  logic clk;
  logic clr_a;
  logic clr_b;
  int   n_chk;
  int   n_err;

  d_flip_flop_if #(.WIDTH(1)) bus_a ();
  d_flip_flop_if #(.WIDTH(8)) bus_b ();

  d_flip_flop #(
    .WIDTH       (1),
    .DEPTH       (1),
    .RESET_VALUE (1'b0)
  ) u_dut_a (
    .CLK (clk),
    .CLR (clr_a),
    .bus (bus_a)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) u_dut_b (
    .CLK (clk),
    .CLR (clr_b),
    .bus (bus_b)
  );

  // Rising edges fall at 10, 20, 30 ns, and falling edges at 5, 15, 25 ns.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic vec [5];
    vec = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    n_chk = 0;
    n_err = 0;

    // Power-up clear with D toggling and the clock running.
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.EN = 1'b1;
    bus_a.D  = 1'b1;
    bus_b.EN = 1'b0;
    bus_b.D  = 8'hFF;
    #1;
    chk("pwr_q_t1", {7'd0, bus_a.Q}, 8'h00);
    chk("pwr_b_q_t1", bus_b.Q, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus_a.D = ~bus_a.D;
      chk("pwr_q", {7'd0, bus_a.Q}, 8'h00);
      chk("pwr_qn", {7'd0, bus_a.QN}, 8'h01);
    end
    chk("pwr_b_q", bus_b.Q, 8'hA5);
    chk("pwr_b_qn", bus_b.QN, 8'h5A);

    // Release clear between edges. Nothing changes until a clock edge.
    @(negedge clk);
    clr_a = 1'b1;
    clr_b = 1'b1;
    bus_a.D = vec[0];
    #1;
    chk("release_q", {7'd0, bus_a.Q}, 8'h00);

    // Basic capture, with a mid-cycle D disturbance after each edge.
    for (int i = 0; i < 5; i++) begin
      bus_a.D = vec[i];
      @(posedge clk);
      #1;
      chk("cap_q", {7'd0, bus_a.Q}, {7'd0, vec[i]});
      chk("cap_qn", {7'd0, bus_a.QN}, {7'd0, ~vec[i]});
      #2;
      bus_a.D = ~vec[i];
      #1;
      chk("cap_midcyc", {7'd0, bus_a.Q}, {7'd0, vec[i]});
      @(negedge clk);
    end

    // Asynchronous clear 2 ns after an edge, held low for 5 ns.
    bus_a.D = 1'b1;
    @(posedge clk);
    #1;
    chk("aclr_pre", {7'd0, bus_a.Q}, 8'h01);
    #1;
    clr_a = 1'b0;
    #1;
    chk("aclr_q", {7'd0, bus_a.Q}, 8'h00);
    chk("aclr_qn", {7'd0, bus_a.QN}, 8'h01);
    #4;
    clr_a = 1'b1;
    #1;
    chk("aclr_after_rel", {7'd0, bus_a.Q}, 8'h00);
    @(posedge clk);
    #1;
    chk("aclr_recap", {7'd0, bus_a.Q}, 8'h01);

    // Clear asserted at the same instant as a rising edge with D=1.
    @(negedge clk);
    bus_a.D = 1'b1;
    @(posedge clk);
    clr_a = 1'b0;
    #1;
    chk("collide_q", {7'd0, bus_a.Q}, 8'h00);
    @(negedge clk);
    clr_a = 1'b1;

    // Enable hold: Q=1, then EN=0 with D=0 for three edges.
    bus_a.D = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_pre", {7'd0, bus_a.Q}, 8'h01);
    bus_a.D  = 1'b0;
    bus_a.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_q", {7'd0, bus_a.Q}, 8'h01);
    end
    @(negedge clk);
    bus_a.EN = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_resume", {7'd0, bus_a.Q}, 8'h00);

    // Delay line: still holding its reset value, since EN has been low.
    chk("dl_rst_q", bus_b.Q, 8'hA5);
    chk("dl_rst_qn", bus_b.QN, 8'h5A);
    @(negedge clk);
    bus_b.EN = 1'b1;
    bus_b.D  = 8'h11;
    @(posedge clk); #1; chk("dl_e1", bus_b.Q, 8'hA5);
    @(negedge clk); bus_b.D = 8'h22;
    @(posedge clk); #1; chk("dl_e2", bus_b.Q, 8'hA5);
    @(negedge clk); bus_b.D = 8'h33;
    @(posedge clk); #1; chk("dl_e3", bus_b.Q, 8'h11);
    chk("dl_e3_qn", bus_b.QN, 8'hEE);
    @(negedge clk); bus_b.D = 8'h44;
    @(posedge clk); #1; chk("dl_e4", bus_b.Q, 8'h22);
    @(negedge clk); bus_b.D = 8'h55;
    @(posedge clk); #1; chk("dl_e5", bus_b.Q, 8'h33);

    // Mid-cycle clear discards every in-flight stage.
    #1;
    clr_b = 1'b0;
    #1;
    chk("dl_clr_q", bus_b.Q, 8'hA5);
    chk("dl_clr_qn", bus_b.QN, 8'h5A);
    @(negedge clk);
    clr_b = 1'b1;
    bus_b.D = 8'h66;
    @(posedge clk); #1; chk("dl_drain1", bus_b.Q, 8'hA5);
    @(posedge clk); #1; chk("dl_drain2", bus_b.Q, 8'hA5);
    @(posedge clk); #1; chk("dl_drain3", bus_b.Q, 8'h66);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
